// File: rtl/wb_pkg.sv
// Shared Wishbone constants, the response-pipeline record and the byte-lane merge helper.
package wb_pkg;
    localparam int WB_DW      = 32;
    localparam int WB_SELW    = 4;
    localparam int WB_MAX_LAT = 4;

    typedef struct packed {
        logic             valid;
        logic             we;
        logic [WB_DW-1:0] dat;
    } wb_rsp_t;

    // Replace each byte of old_w whose select bit is set with the matching byte of new_w.
    function automatic logic [WB_DW-1:0] merge_bytes(input logic [WB_DW-1:0]   old_w,
                                                     input logic [WB_DW-1:0]   new_w,
                                                     input logic [WB_SELW-1:0] sel);
        logic [WB_DW-1:0] res;
        res = old_w;
        for (int b = 0; b < WB_SELW; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction
endpackage

// File: rtl/if_wb.sv
// Wishbone bus bundle; dat_m flows master->slave, dat_s flows slave->master.
interface if_wb;
    import wb_pkg::*;
    logic               cyc;
    logic               stb;
    logic               we;
    logic [WB_SELW-1:0] sel;
    logic [31:0]        adr;
    logic [WB_DW-1:0]   dat_m;
    logic [WB_DW-1:0]   dat_s;
    logic               ack;
    logic               stall;

    modport slave  (input cyc, stb, we, sel, adr, dat_m, output ack, dat_s, stall);
    modport master (output cyc, stb, we, sel, adr, dat_m, input ack, dat_s, stall);
endinterface

// File: rtl/bytemem.sv
// Single-port synchronous RAM with byte enables and a registered, write-first read port.
module bytemem
    import wb_pkg::*;
#(
    parameter int AWIDTH = 14
) (
    input  logic               clk_i,
    input  logic               en_i,
    input  logic               we_i,
    input  logic [WB_SELW-1:0] sel_i,
    input  logic [AWIDTH-1:0]  addr_i,
    input  logic [WB_DW-1:0]   wdat_i,
    output logic [WB_DW-1:0]   rdat_o
);
    logic [WB_DW-1:0] mem_q [2**AWIDTH];
    logic [WB_DW-1:0] rdat_q;
    logic [WB_DW-1:0] wr_word_s;

    assign wr_word_s = merge_bytes(mem_q[addr_i], wdat_i, sel_i);

    // Storage is deliberately left out of reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wr_word_s;
                rdat_q        <= wr_word_s;
            end else begin
                rdat_q <= mem_q[addr_i];
            end
        end
    end

    assign rdat_o = rdat_q;
endmodule

// File: rtl/wb_vram_responder.sv
// Zero-stall Wishbone responder for a frame buffer: one request per cycle, in-order acks
// after a fixed LATENCY through a {valid, we, data} shift register.
module wb_vram_responder
    import wb_pkg::*;
#(
    parameter int AWIDTH  = 14,
    parameter int LATENCY = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    if_wb.slave  bus
);
    localparam int CW = $clog2(LATENCY + 1);

    logic             acc_s;
    logic             ack_s;
    logic [AWIDTH-1:0] widx_s;
    logic [WB_DW-1:0] rdat_s;
    logic [WB_DW-1:0] head_dat_s;
    wb_rsp_t          pipe_q [LATENCY];
    wb_rsp_t          pipe_d [LATENCY];
    logic [CW-1:0]    outst_q;
    logic [CW-1:0]    outst_d;

    assign acc_s  = bus.cyc & bus.stb;
    assign widx_s = bus.adr[AWIDTH+1:2];

    bytemem #(.AWIDTH(AWIDTH)) u_mem (
        .clk_i  (clk_i),
        .en_i   (acc_s),
        .we_i   (bus.we),
        .sel_i  (bus.sel),
        .addr_i (widx_s),
        .wdat_i (bus.dat_m),
        .rdat_o (rdat_s)
    );

    // Stage 0 carries no data: the RAM output register already holds it, so stage 1 picks it up.
    assign pipe_d[0] = bus.cyc ? wb_rsp_t'({acc_s, bus.we, 32'h0}) : '0;
    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        if (g == 1) begin : g_first
            assign pipe_d[g] = bus.cyc ? wb_rsp_t'({pipe_q[0].valid, pipe_q[0].we, rdat_s}) : '0;
        end else begin : g_rest
            assign pipe_d[g] = bus.cyc ? pipe_q[g-1] : '0;
        end
    end

    assign ack_s      = pipe_q[LATENCY-1].valid;
    assign head_dat_s = (LATENCY == 1) ? rdat_s : pipe_q[LATENCY-1].dat;

    // Dropping cyc abandons every in-flight response, so the count collapses to zero.
    always_comb begin
        outst_d = outst_q;
        if (!bus.cyc) begin
            outst_d = '0;
        end else begin
            outst_d = outst_q + CW'(acc_s) - CW'(ack_s);
        end
    end

    // Response pipeline and outstanding counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            outst_q <= '0;
        end else begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            outst_q <= outst_d;
        end
    end

    assign bus.ack   = ack_s;
    assign bus.dat_s = (ack_s && !pipe_q[LATENCY-1].we) ? head_dat_s : 32'h0;
    assign bus.stall = 1'b0;
endmodule

// File: tb/tb_wb_vram_responder.sv
// Scoreboard bench: three responder instances (L1/AW14, L3/AW14, L2/AW4) driven by directed vectors.
module tb_wb_vram_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cyc_s  [3];
    logic        stb_s  [3];
    logic        we_s   [3];
    logic [3:0]  sel_s  [3];
    logic [31:0] adr_s  [3];
    logic [31:0] datm_s [3];
    logic        ack_s  [3];
    logic        stall_s[3];
    logic [31:0] dats_s [3];

    int cyc_n   = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int peak0   = 0;
    int peak1   = 0;

    typedef struct {
        int          u;
        int          due;
        logic [31:0] dat;
    } exp_t;
    exp_t sb[$];

    for (genvar g = 0; g < 3; g++) begin : g_u
        if_wb bus ();
        assign bus.cyc    = cyc_s[g];
        assign bus.stb    = stb_s[g];
        assign bus.we     = we_s[g];
        assign bus.sel    = sel_s[g];
        assign bus.adr    = adr_s[g];
        assign bus.dat_m  = datm_s[g];
        assign ack_s[g]   = bus.ack;
        assign stall_s[g] = bus.stall;
        assign dats_s[g]  = bus.dat_s;

        wb_vram_responder #(
            .AWIDTH  (g == 2 ? 4 : 14),
            .LATENCY (g == 0 ? 1 : (g == 1 ? 3 : 2))
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : ((u == 1) ? 3 : 2);
    endfunction

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s unit%0d cycle %0d: got %h expected %h", name, u, cyc_n, act, exp);
        end
    endtask

    // Remove responses that a cyc drop or reset at the coming edge will discard.
    task automatic flush(input int u);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].u == u && sb[i].due > cyc_n) sb.delete(i);
        end
    endtask

    task automatic step(input int u, input logic c, input logic s, input logic w, input logic [3:0] sel,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] exp);
        exp_t e;
        @(negedge clk);
        cyc_s[u]  = c;
        stb_s[u]  = s;
        we_s[u]   = w;
        sel_s[u]  = sel;
        adr_s[u]  = adr;
        datm_s[u] = dat;
        if (!c) begin
            flush(u);
        end else if (s) begin
            e.u   = u;
            e.due = cyc_n + lat_of(u);
            e.dat = w ? 32'h0 : exp;
            sb.push_back(e);
        end
    endtask

    task automatic wr(input int u, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        step(u, 1'b1, 1'b1, 1'b1, sel, adr, dat, 32'h0);
    endtask

    task automatic rd(input int u, input logic [31:0] adr, input logic [31:0] exp);
        step(u, 1'b1, 1'b1, 1'b0, 4'hF, adr, 32'h0, exp);
    endtask

    task automatic hold(input int u);
        step(u, 1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic drop(input int u);
        step(u, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
    endtask

    // Monitor: every unit, every cycle, against the oldest pending response for that unit.
    always @(negedge clk) begin : mon
        int idx;
        for (int u = 0; u < 3; u++) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) begin
                if (idx < 0 && sb[i].u == u) idx = i;
            end
            check("stall", u, {31'h0, stall_s[u]}, 32'h0);
            if (idx < 0) begin
                check("spurious_ack", u, {31'h0, ack_s[u]}, 32'h0);
            end else if (sb[idx].due > cyc_n) begin
                check("early_ack", u, {31'h0, ack_s[u]}, 32'h0);
            end else begin
                check("ack_due", u, {31'h0, ack_s[u]}, 32'h1);
                if (ack_s[u]) check("ack_data", u, dats_s[u], sb[idx].dat);
                sb.delete(idx);
            end
            if (!ack_s[u]) check("dat_idle", u, dats_s[u], 32'h0);
        end
        if (int'(g_u[0].u_dut.outst_q) > peak0) peak0 = int'(g_u[0].u_dut.outst_q);
        if (int'(g_u[1].u_dut.outst_q) > peak1) peak1 = int'(g_u[1].u_dut.outst_q);
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 3; u++) begin
            cyc_s[u] = 1'b0; stb_s[u] = 1'b0; we_s[u] = 1'b0;
            sel_s[u] = 4'h0; adr_s[u] = 32'h0; datm_s[u] = 32'h0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // LATENCY=1: preload, 20-read burst, byte-lane merge with immediate read-back.
        for (int i = 0; i < 20; i++) wr(0, 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 20; i++) rd(0, 32'(i * 4), 32'hA000_0000 + 32'(i));
        wr(0, 32'h10, 32'h1122_3344, 4'b1111);
        wr(0, 32'h10, 32'hAABB_CCDD, 4'b0101);
        rd(0, 32'h10, 32'h11BB_33DD);
        hold(0);
        drop(0);

        // LATENCY=3: 8 back-to-back reads, then a cyc drop after 5 reads, then a 2-read burst.
        for (int i = 0; i < 8; i++) wr(1, 32'(i * 4), 32'hB000_0000 + 32'(i), 4'hF);
        for (int i = 0; i < 8; i++) rd(1, 32'(i * 4), 32'hB000_0000 + 32'(i));
        repeat (3) hold(1);
        drop(1);
        for (int i = 0; i < 5; i++) rd(1, 32'(i * 4), 32'hB000_0000 + 32'(i));
        drop(1);
        drop(1);
        rd(1, 32'h14, 32'hB000_0005);
        rd(1, 32'h18, 32'hB000_0006);
        repeat (3) hold(1);
        drop(1);

        // LATENCY=2, AWIDTH=4: reset with two reads in flight, then wrap and alias reads.
        for (int i = 0; i < 8; i++) wr(2, 32'(i * 4), 32'hC000_0000 + 32'(i), 4'hF);
        repeat (2) hold(2);
        rd(2, 32'h4, 32'hC000_0001);
        rd(2, 32'h8, 32'hC000_0002);
        rst = 1'b1;
        for (int u = 0; u < 3; u++) flush(u);
        drop(2);
        rst = 1'b0;
        drop(2);
        rd(2, 32'h40, 32'hC000_0000);
        rd(2, 32'h13, 32'hC000_0004);
        rd(2, 32'h4,  32'hC000_0001);
        repeat (2) hold(2);
        drop(2);

        repeat (5) @(negedge clk);
        #1;
        check("sb_drained", 0, 32'(sb.size()), 32'h0);
        check("outst_peak", 0, 32'(peak0), 32'd1);
        check("outst_peak", 1, 32'(peak1), 32'd3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
